// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the instruction producer/result consumer/ALU (master side)
// and the ALU issue controller (slave side).
interface alu_issue_ctrl_if #(
  parameter int DW = 32,
  parameter int FW = 6
);
  // Both handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both high; once raised, valid and its payload hold until then.
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [FW-1:0] alu_func;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_y;
  logic          alu_n;
  logic          alu_z;
  logic          alu_c;
  logic          alu_v;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] result;
  logic [3:0]    flags;
  logic          illegal;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  modport master (
    output instr_valid, instr, rs_val, rt_val,
    input  instr_ready,
    input  alu_func, alu_a, alu_b,
    output alu_y, alu_n, alu_z, alu_c, alu_v,
    input  res_valid, result, flags, illegal, hi, lo,
    output res_ready
  );

  modport slave (
    input  instr_valid, instr, rs_val, rt_val,
    output instr_ready,
    output alu_func, alu_a, alu_b,
    input  alu_y, alu_n, alu_z, alu_c, alu_v,
    output res_valid, result, flags, illegal, hi, lo,
    input  res_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded MIPS instruction at a time to a combinational ALU,
// sequences MULT into HI/LO and serves MFHI/MFLO from the local registers.
module alu_issue_ctrl #(
  parameter int DW = 32,
  parameter int FW = 6
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    MUL_LO = 3'd2,
    MUL_HI = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [FW-1:0] F_MUL_LO = 6'b011001;
  localparam logic [FW-1:0] F_MUL_HI = 6'b011010;

  state_t        state, state_nx;
  logic          accept;
  logic [FW-1:0] func_q;
  logic [DW-1:0] a_q, b_q, result_q, hi_q, lo_q;
  logic [3:0]    flags_q;
  logic          illegal_q;

  logic [5:0]    opcode, funct;
  logic [DW-1:0] shamt_z, rs5_z, imm_s;
  logic          dec_alu, dec_mul, dec_hi_sel, dec_illegal;
  logic [FW-1:0] dec_func;
  logic [DW-1:0] dec_a, dec_b, local_val;
  logic [3:0]    local_flags;

  assign opcode  = bus.instr[31:26];
  assign funct   = bus.instr[5:0];
  assign shamt_z = {{(DW-5){1'b0}}, bus.instr[10:6]};
  assign rs5_z   = {{(DW-5){1'b0}}, bus.rs_val[4:0]};
  assign imm_s   = {{(DW-16){bus.instr[15]}}, bus.instr[15:0]};

  always_comb begin
    dec_alu     = 1'b0;
    dec_mul     = 1'b0;
    dec_hi_sel  = 1'b0;
    dec_illegal = 1'b0;
    dec_func    = '0;
    dec_a       = '0;
    dec_b       = '0;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b100000, 6'b100001, 6'b100011, 6'b100101: begin
          dec_alu = 1'b1; dec_func = funct; dec_a = bus.rs_val; dec_b = bus.rt_val;
        end
        6'b000000: begin dec_alu = 1'b1; dec_func = 6'b111000; dec_a = shamt_z; dec_b = bus.rt_val; end
        6'b000010: begin dec_alu = 1'b1; dec_func = 6'b110110; dec_a = shamt_z; dec_b = bus.rt_val; end
        6'b000011: begin dec_alu = 1'b1; dec_func = 6'b111110; dec_a = shamt_z; dec_b = bus.rt_val; end
        6'b000100: begin dec_alu = 1'b1; dec_func = 6'b111100; dec_a = bus.rt_val; dec_b = rs5_z; end
        6'b000110: begin dec_alu = 1'b1; dec_func = 6'b101110; dec_a = bus.rt_val; dec_b = rs5_z; end
        6'b000111: begin dec_alu = 1'b1; dec_func = 6'b111001; dec_a = rs5_z; dec_b = bus.rt_val; end
        6'b011000: begin dec_mul = 1'b1; dec_func = F_MUL_LO; dec_a = bus.rs_val; dec_b = bus.rt_val; end
        6'b010000: dec_hi_sel = 1'b1;
        6'b010010: dec_hi_sel = 1'b0;
        default:   dec_illegal = 1'b1;
      endcase
    end else if (opcode == 6'b001001) begin
      dec_alu = 1'b1; dec_func = 6'b001001; dec_a = bus.rs_val; dec_b = imm_s;
    end else begin
      dec_illegal = 1'b1;
    end
  end

  // Locally answered instructions: MFHI/MFLO read HI/LO, illegal ones return zero.
  assign local_val   = dec_illegal ? '0 : (dec_hi_sel ? hi_q : lo_q);
  assign local_flags = dec_illegal ? 4'b0000 : {local_val[DW-1], local_val == '0, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (bus.instr_valid) begin
        accept = 1'b1;
        if (dec_alu)      state_nx = EXEC;
        else if (dec_mul) state_nx = MUL_LO;
        else              state_nx = RESP;
      end
      EXEC:    state_nx = RESP;
      MUL_LO:  state_nx = MUL_HI;
      MUL_HI:  state_nx = RESP;
      RESP:    if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      func_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          func_q    <= dec_func;
          a_q       <= dec_a;
          b_q       <= dec_b;
          illegal_q <= dec_illegal;
          if (!dec_alu && !dec_mul) begin
            result_q <= local_val;
            flags_q  <= local_flags;
          end
        end
        EXEC: begin
          result_q <= bus.alu_y;
          flags_q  <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
          func_q   <= '0;
          a_q      <= '0;
          b_q      <= '0;
        end
        MUL_LO: begin
          lo_q   <= bus.alu_y;
          func_q <= F_MUL_HI;
        end
        // LO already holds the low product, so the response carries it.
        MUL_HI: begin
          hi_q     <= bus.alu_y;
          result_q <= lo_q;
          flags_q  <= {bus.alu_n, bus.alu_z, 2'b00};
          func_q   <= '0;
          a_q      <= '0;
          b_q      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.res_valid   = (state == RESP);
  assign bus.alu_func    = func_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.result      = result_q;
  assign bus.flags       = flags_q;
  assign bus.illegal     = illegal_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign dbg_state       = state;
endmodule
